// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Function : 4x4 matrix keypad column scanner with row debounce; emits one
//            enter strobe plus key code per debounced press.
// Revision : 1.0
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       enter,
  output logic [3:0] digit
);

  localparam int c_CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_DWELL_LAST = c_CNT_W'(SCAN_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_DEB_DONE   = c_CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

  localparam logic [1:0] S_SCAN         = 2'd0;
  localparam logic [1:0] S_DEBOUNCE     = 2'd1;
  localparam logic [1:0] S_EMIT         = 2'd2;
  localparam logic [1:0] S_WAIT_RELEASE = 2'd3;

  logic [3:0]         r_sync1;
  logic [3:0]         r_rs;
  logic [1:0]         r_state;
  logic [1:0]         r_col_idx;
  logic [c_CNT_W-1:0] r_dwell;
  logic [c_CNT_W-1:0] r_deb_cnt;
  logic [3:0]         r_row_lat;
  logic [3:0]         r_digit;

  logic [1:0]         w_state_nxt;
  logic [1:0]         w_col_idx_nxt;
  logic [c_CNT_W-1:0] w_dwell_nxt;
  logic [c_CNT_W-1:0] w_deb_nxt;
  logic [3:0]         w_row_lat_nxt;
  logic [3:0]         w_digit_nxt;
  logic [3:0]         w_low;
  logic               w_single;

  function automatic logic [3:0] key_code(input logic [3:0] lat, input logic [1:0] c);
    logic [1:0] r;
    logic [3:0] code;
    case (lat)
      4'b1110: r = 2'd0;
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      default: r = 2'd3;
    endcase
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Rows are asynchronous to clk; only the second flop's value is ever used.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 4'hF;
      r_rs    <= 4'hF;
    end else begin
      r_sync1 <= row;
      r_rs    <= r_sync1;
    end
  end

  assign w_low    = ~r_rs;
  assign w_single = (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_SCAN;
      r_col_idx <= 2'd0;
      r_dwell   <= '0;
      r_deb_cnt <= '0;
      r_row_lat <= 4'hF;
      r_digit   <= 4'h0;
    end else begin
      r_state   <= w_state_nxt;
      r_col_idx <= w_col_idx_nxt;
      r_dwell   <= w_dwell_nxt;
      r_deb_cnt <= w_deb_nxt;
      r_row_lat <= w_row_lat_nxt;
      r_digit   <= w_digit_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_col_idx_nxt = r_col_idx;
    w_dwell_nxt   = r_dwell;
    w_deb_nxt     = r_deb_cnt;
    w_row_lat_nxt = r_row_lat;
    w_digit_nxt   = r_digit;
    case (r_state)
      S_SCAN: begin
        if (r_dwell == c_DWELL_LAST) begin
          w_dwell_nxt = '0;
          if (w_single) begin
            w_row_lat_nxt = r_rs;
            w_deb_nxt     = '0;
            w_state_nxt   = S_DEBOUNCE;
          end else begin
            w_col_idx_nxt = r_col_idx + 2'd1;
          end
        end else begin
          w_dwell_nxt = r_dwell + c_CNT_ONE;
        end
      end
      S_DEBOUNCE: begin
        if (r_rs != r_row_lat) begin
          w_deb_nxt     = '0;
          w_dwell_nxt   = '0;
          w_col_idx_nxt = r_col_idx + 2'd1;
          w_state_nxt   = S_SCAN;
        end else if (r_deb_cnt == c_DEB_DONE) begin
          w_digit_nxt = key_code(r_row_lat, r_col_idx);
          w_state_nxt = S_EMIT;
        end else begin
          w_deb_nxt = r_deb_cnt + c_CNT_ONE;
        end
      end
      S_EMIT: begin
        w_deb_nxt   = '0;
        w_state_nxt = S_WAIT_RELEASE;
      end
      default: begin
        // Release must be as stable as the press before scanning resumes.
        if (r_rs != 4'hF) begin
          w_deb_nxt = '0;
        end else if (r_deb_cnt == c_DEB_DONE) begin
          w_deb_nxt     = '0;
          w_dwell_nxt   = '0;
          w_col_idx_nxt = r_col_idx + 2'd1;
          w_state_nxt   = S_SCAN;
        end else begin
          w_deb_nxt = r_deb_cnt + c_CNT_ONE;
        end
      end
    endcase
  end

  always_comb begin
    col   = ~(4'b0001 << r_col_idx);
    enter = (r_state == S_EMIT);
    digit = r_digit;
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Function : scoreboard bench for keypad_scanner with a behavioural keypad.
// Revision : 1.0
// ============================================================================
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        enter;
  logic [3:0]  digit;
  logic [15:0] keys = 16'h0;

  int total = 0;
  int bad = 0;
  int edges = 0;
  int exp_cyc = -1;
  logic [3:0] exp_q[$];
  logic prev_enter = 1'b0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .enter(enter), .digit(digit)
  );

  always #5 clk = ~clk;

  // Key (r,c) held pulls row r low while column c is driven.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  always @(posedge clk) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int idx, input logic [3:0] code, input int hold, input int gap);
    exp_q.push_back(code);
    keys[idx] = 1'b1;
    cycles(hold);
    keys[idx] = 1'b0;
    cycles(gap);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (enter) begin
          check("enter_gap", int'(prev_enter), 0);
          if (exp_q.size() == 0) check("unexpected_enter", 1, 0);
          else check("digit", int'(digit), int'(exp_q.pop_front()));
          if (exp_cyc >= 0) begin
            check("latency", edges, exp_cyc);
            exp_cyc = -1;
          end
        end
        prev_enter = enter;
      end
    join_none

    // Reset state and idle column rotation
    @(negedge clk);
    reset = 1'b1;
    cycles(2);
    check("rst_col", int'(col), 4'b1110);
    check("rst_enter", int'(enter), 0);
    check("rst_digit", int'(digit), 0);
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      case (i)
        3:  check("rot_hold", int'(col), 4'b1110);
        4:  check("rot_c1", int'(col), 4'b1101);
        8:  check("rot_c2", int'(col), 4'b1011);
        12: check("rot_c3", int'(col), 4'b0111);
        16: check("rot_wrap", int'(col), 4'b1110);
        default: ;
      endcase
    end

    // Single press held through reset release: detection on the 4th edge,
    // enter on the 13th edge after reset deasserts.
    reset = 1'b1;
    keys[4] = 1'b1;
    cycles(2);
    exp_q.push_back(4'h4);
    exp_cyc = 13;
    reset = 1'b0;
    cycles(200);
    keys[4] = 1'b0;
    cycles(60);
    check("latency_seen", exp_cyc, -1);

    // Password 4,1,3,2
    press(4, 4'h4, 60, 60);
    press(0, 4'h1, 60, 60);
    press(2, 4'h3, 60, 60);
    press(1, 4'h2, 60, 60);

    // Bounce on key 8 is rejected, then a clean hold is accepted
    for (int b = 0; b < 8; b++) begin
      keys[9] = 1'b1;
      cycles(3);
      keys[9] = 1'b0;
      cycles(2);
    end
    cycles(20);
    check("bounce_none", exp_q.size(), 0);
    press(9, 4'h8, 60, 60);

    // Two keys in one column are ignored
    keys[0] = 1'b1;
    keys[4] = 1'b1;
    cycles(60);
    keys[0] = 1'b0;
    keys[4] = 1'b0;
    cycles(20);

    // Short release glitch while waiting for release yields no second enter
    exp_q.push_back(4'h0);
    keys[13] = 1'b1;
    cycles(40);
    keys[13] = 1'b0;
    cycles(3);
    keys[13] = 1'b1;
    cycles(30);
    keys[13] = 1'b0;
    cycles(60);

    // Reset mid-debounce: key on column 2 is detected on edge 12 after reset
    reset = 1'b1;
    keys[14] = 1'b1;
    cycles(2);
    reset = 1'b0;
    for (int w = 0; w < 40 && edges != 15; w++) @(negedge clk);
    check("sync_edges", edges, 15);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_col", int'(col), 4'b1110);
    check("midrst_enter", int'(enter), 0);
    reset = 1'b0;
    exp_q.push_back(4'hF);
    cycles(60);
    keys[14] = 1'b0;
    cycles(60);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
